// File: rtl/dm_cmd_master_if.sv
// AXI4-Lite bus between dm_cmd_master and the data-mover register slave.
// Address width is a parameter so the bus matches the slave's register window.
interface dm_cmd_master_if #(
    parameter int AW = 8
);
    logic [AW-1:0] M_AXI_AWADDR;
    logic [2:0]    M_AXI_AWPROT;
    logic          M_AXI_AWVALID;
    logic          M_AXI_AWREADY;
    logic [31:0]   M_AXI_WDATA;
    logic [3:0]    M_AXI_WSTRB;
    logic          M_AXI_WVALID;
    logic          M_AXI_WREADY;
    logic [1:0]    M_AXI_BRESP;
    logic          M_AXI_BVALID;
    logic          M_AXI_BREADY;
    logic [AW-1:0] M_AXI_ARADDR;
    logic [2:0]    M_AXI_ARPROT;
    logic          M_AXI_ARVALID;
    logic          M_AXI_ARREADY;
    logic [31:0]   M_AXI_RDATA;
    logic [1:0]    M_AXI_RRESP;
    logic          M_AXI_RVALID;
    logic          M_AXI_RREADY;

    modport master (
        output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        input  M_AXI_AWREADY,
        output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        input  M_AXI_WREADY,
        input  M_AXI_BRESP, M_AXI_BVALID,
        output M_AXI_BREADY,
        output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        input  M_AXI_ARREADY,
        input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        output M_AXI_RREADY
    );

    modport slave (
        input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID,
        output M_AXI_AWREADY,
        input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
        output M_AXI_WREADY,
        output M_AXI_BRESP, M_AXI_BVALID,
        input  M_AXI_BREADY,
        input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID,
        output M_AXI_ARREADY,
        output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/dm_cmd_master.sv
// AXI4-Lite initiator: programs the data-mover registers for one copy command,
// writes START, polls busy until clear, then pulses done with the error status.
module dm_cmd_master #(
    parameter int            AW        = 8,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int            POLL_GAP  = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [63:0]     cmd_src,
    input  logic [63:0]     cmd_dst,
    input  logic [63:0]     cmd_count,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_resp,
    dm_cmd_master_if.master m_axi
);

    localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WADDR, S_WRESP, S_GAP, S_RADDR, S_RDATA, S_DONE
    } state_t;

    state_t        r_state;
    logic [63:0]   r_src;
    logic [63:0]   r_dst;
    logic [63:0]   r_cnt;
    logic [2:0]    r_widx;
    logic          r_issued;
    logic          r_aw_done;
    logic          r_w_done;
    logic [GW-1:0] r_gap_cnt;
    logic          r_awvalid;
    logic          r_wvalid;
    logic          r_bready;
    logic          r_arvalid;
    logic          r_rready;
    logic [AW-1:0] r_awaddr;
    logic [31:0]   r_wdata;
    logic [AW-1:0] r_araddr;
    logic          r_done;
    logic          r_err;
    logic [1:0]    r_err_resp;

    logic          w_aw_hs;
    logic          w_w_hs;
    logic          w_b_hs;
    logic          w_ar_hs;
    logic          w_r_hs;
    logic [2:0]    w_next_idx;
    logic [31:0]   w_reg_data [0:7];
    logic [AW-1:0] w_reg_addr [0:7];

    // Register image: index 0 is START, odd/even pairs are high/low halves.
    assign w_reg_data[0] = 32'h1;
    assign w_reg_data[7] = 32'h0;
    for (genvar gi = 0; gi < 3; gi++) begin : g_halves
        logic [63:0] w_field;
        assign w_field = (gi == 0) ? r_src : ((gi == 1) ? r_dst : r_cnt);
        assign w_reg_data[2*gi+1] = w_field[63:32];
        assign w_reg_data[2*gi+2] = w_field[31:0];
    end

    for (genvar gi = 0; gi < 8; gi++) begin : g_addr
        assign w_reg_addr[gi] = (gi < 7) ? BASE_ADDR + AW'(4 * gi) : BASE_ADDR;
    end

    assign w_aw_hs    = r_awvalid && m_axi.M_AXI_AWREADY;
    assign w_w_hs     = r_wvalid  && m_axi.M_AXI_WREADY;
    assign w_b_hs     = r_bready  && m_axi.M_AXI_BVALID;
    assign w_ar_hs    = r_arvalid && m_axi.M_AXI_ARREADY;
    assign w_r_hs     = r_rready  && m_axi.M_AXI_RVALID;
    assign w_next_idx = (r_widx == 3'd6) ? 3'd0 : r_widx + 3'd1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_src      <= '0;
            r_dst      <= '0;
            r_cnt      <= '0;
            r_widx     <= '0;
            r_issued   <= 1'b0;
            r_aw_done  <= 1'b0;
            r_w_done   <= 1'b0;
            r_gap_cnt  <= '0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_arvalid  <= 1'b0;
            r_rready   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_araddr   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_resp <= 2'b00;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_src    <= cmd_src;
                        r_dst    <= cmd_dst;
                        r_cnt    <= cmd_count;
                        r_widx   <= 3'd1;
                        r_issued <= 1'b0;
                        r_state  <= S_WADDR;
                    end
                end

                // First cycle presents AW and W; afterwards each drops on its own handshake.
                S_WADDR: begin
                    if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_awaddr  <= w_reg_addr[r_widx];
                        r_wdata   <= w_reg_data[r_widx];
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        if (w_aw_hs) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_hs) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
                            r_bready <= 1'b1;
                            r_state  <= S_WRESP;
                        end
                    end
                end

                S_WRESP: begin
                    if (w_b_hs) begin
                        r_bready <= 1'b0;
                        if (m_axi.M_AXI_BRESP != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_resp <= m_axi.M_AXI_BRESP;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (r_widx == 3'd0) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_widx   <= w_next_idx;
                            r_issued <= 1'b0;
                            r_state  <= S_WADDR;
                        end
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == GW'(POLL_GAP - 1)) begin
                        r_issued <= 1'b0;
                        r_state  <= S_RADDR;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                S_RADDR: begin
                    if (!r_issued) begin
                        r_issued  <= 1'b1;
                        r_arvalid <= 1'b1;
                        r_araddr  <= BASE_ADDR;
                    end else if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end

                // Busy bit set means the mover is still running: wait and poll again.
                S_RDATA: begin
                    if (w_r_hs) begin
                        r_rready <= 1'b0;
                        if (m_axi.M_AXI_RRESP != 2'b00) begin
                            r_err      <= 1'b1;
                            r_err_resp <= m_axi.M_AXI_RRESP;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end else if (m_axi.M_AXI_RDATA[0]) begin
                            r_gap_cnt <= '0;
                            r_state   <= S_GAP;
                        end else begin
                            r_err      <= 1'b0;
                            r_err_resp <= 2'b00;
                            r_done     <= 1'b1;
                            r_state    <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == S_IDLE) && resetn;
    assign done      = r_done;
    assign err       = r_err;
    assign err_resp  = r_err_resp;

    assign m_axi.M_AXI_AWADDR  = r_awaddr;
    assign m_axi.M_AXI_AWPROT  = 3'b000;
    assign m_axi.M_AXI_AWVALID = r_awvalid;
    assign m_axi.M_AXI_WDATA   = r_wdata;
    assign m_axi.M_AXI_WSTRB   = 4'hF;
    assign m_axi.M_AXI_WVALID  = r_wvalid;
    assign m_axi.M_AXI_BREADY  = r_bready;
    assign m_axi.M_AXI_ARADDR  = r_araddr;
    assign m_axi.M_AXI_ARPROT  = 3'b000;
    assign m_axi.M_AXI_ARVALID = r_arvalid;
    assign m_axi.M_AXI_RREADY  = r_rready;

endmodule

// File: tb/tb_dm_cmd_master.sv
// Directed bench for dm_cmd_master against a small AXI4-Lite register-slave model.
module tb_dm_cmd_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [63:0] cmd_src = '0;
    logic [63:0] cmd_dst = '0;
    logic [63:0] cmd_count = '0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        done;
    logic        err;
    logic [1:0]  err_resp;

    dm_cmd_master_if #(.AW(8)) bus ();

    dm_cmd_master #(.AW(8), .BASE_ADDR(8'h40), .POLL_GAP(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .cmd_src   (cmd_src),
        .cmd_dst   (cmd_dst),
        .cmd_count (cmd_count),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .done      (done),
        .err       (err),
        .err_resp  (err_resp),
        .m_axi     (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Slave model knobs, written only by the stimulus block.
    int aw_delay = 0;
    int w_delay = 0;
    int busy_cycles = 60;
    int berr_at = 0;
    int rerr_at = 0;

    // Slave model state.
    int          aw_wait, w_wait, busy_cnt;
    int          beat_n = 0;
    int          rd_n = 0;
    logic        got_aw, got_w, s_bvalid, s_rvalid;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata, cur_data, dst_h, dst_l;
    logic [7:0]  cur_addr;
    logic [7:0]  wr_addr, wr_off;
    logic [31:0] wr_dat;
    logic        aw_hs, w_hs, ar_hs;

    assign bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_wait >= aw_delay);
    assign bus.M_AXI_WREADY  = bus.M_AXI_WVALID && (w_wait >= w_delay);
    assign bus.M_AXI_BVALID  = s_bvalid;
    assign bus.M_AXI_BRESP   = s_bresp;
    assign bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;
    assign bus.M_AXI_RVALID  = s_rvalid;
    assign bus.M_AXI_RRESP   = s_rresp;
    assign bus.M_AXI_RDATA   = s_rdata;

    assign aw_hs   = bus.M_AXI_AWVALID && bus.M_AXI_AWREADY;
    assign w_hs    = bus.M_AXI_WVALID && bus.M_AXI_WREADY;
    assign ar_hs   = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
    assign wr_addr = got_aw ? cur_addr : bus.M_AXI_AWADDR;
    assign wr_dat  = got_w ? cur_data : bus.M_AXI_WDATA;
    assign wr_off  = wr_addr - 8'h40;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_wait  <= 0;
            w_wait   <= 0;
            got_aw   <= 1'b0;
            got_w    <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= 2'b00;
            s_rvalid <= 1'b0;
            s_rresp  <= 2'b00;
            s_rdata  <= '0;
            busy_cnt <= 0;
            cur_addr <= '0;
            cur_data <= '0;
        end else begin
            aw_wait <= (bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY) ? aw_wait + 1 : 0;
            w_wait  <= (bus.M_AXI_WVALID && !bus.M_AXI_WREADY) ? w_wait + 1 : 0;
            if (aw_hs) begin
                got_aw   <= 1'b1;
                cur_addr <= bus.M_AXI_AWADDR;
            end
            if (w_hs) begin
                got_w    <= 1'b1;
                cur_data <= bus.M_AXI_WDATA;
            end
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
            if (s_bvalid && bus.M_AXI_BREADY) s_bvalid <= 1'b0;
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                got_aw   <= 1'b0;
                got_w    <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= (beat_n + 1 == berr_at) ? 2'b11 : 2'b00;
                beat_n   <= beat_n + 1;
                case (wr_off[4:2])
                    3'd3: dst_h <= wr_dat;
                    3'd4: dst_l <= wr_dat;
                    3'd0: if (wr_dat[0] && (dst_h != 0 || dst_l != 0)) busy_cnt <= busy_cycles;
                    default: ;
                endcase
            end
            if (s_rvalid && bus.M_AXI_RREADY) s_rvalid <= 1'b0;
            if (ar_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= {31'b0, busy_cnt > 0};
                s_rresp  <= (rd_n + 1 == rerr_at) ? 2'b10 : 2'b00;
                rd_n     <= rd_n + 1;
            end
        end
    end

    // Bus monitor: handshake logs, stability violations, accepts and done strobes.
    logic [7:0]  aw_log [0:127];
    logic [31:0] w_log  [0:127];
    int          acc_cyc [0:15];
    int          done_cyc [0:15];
    int          aw_n = 0, w_n = 0, ar_n = 0, ar_bad = 0, acc_n = 0, done_n = 0, cyc = 0;
    int          stab_aw = 0, stab_w = 0, stab_ar = 0;
    logic        last_err = 1'b0;
    logic [1:0]  last_resp = 2'b00;
    logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
    logic [7:0]  p_awaddr = '0, p_araddr = '0;
    logic [31:0] p_wdata = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (aw_hs && aw_n < 128) begin
            aw_log[aw_n] <= bus.M_AXI_AWADDR;
            aw_n <= aw_n + 1;
        end
        if (w_hs && w_n < 128) begin
            w_log[w_n] <= bus.M_AXI_WDATA;
            w_n <= w_n + 1;
        end
        if (ar_hs) begin
            ar_n <= ar_n + 1;
            if (bus.M_AXI_ARADDR != 8'h40) ar_bad <= ar_bad + 1;
        end
        if (cmd_valid && cmd_ready && acc_n < 16) begin
            acc_cyc[acc_n] <= cyc;
            acc_n <= acc_n + 1;
        end
        if (done && done_n < 16) begin
            done_cyc[done_n] <= cyc;
            done_n <= done_n + 1;
            last_err <= err;
            last_resp <= err_resp;
        end
        if (resetn && p_aw && (!bus.M_AXI_AWVALID || bus.M_AXI_AWADDR != p_awaddr)) stab_aw <= stab_aw + 1;
        if (resetn && p_w && (!bus.M_AXI_WVALID || bus.M_AXI_WDATA != p_wdata)) stab_w <= stab_w + 1;
        if (resetn && p_ar && (!bus.M_AXI_ARVALID || bus.M_AXI_ARADDR != p_araddr)) stab_ar <= stab_ar + 1;
        p_aw     <= resetn && bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
        p_w      <= resetn && bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
        p_ar     <= resetn && bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
        p_awaddr <= bus.M_AXI_AWADDR;
        p_wdata  <= bus.M_AXI_WDATA;
        p_araddr <= bus.M_AXI_ARADDR;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [63:0] s, input logic [63:0] d, input logic [63:0] c);
        int t;
        int a0;
        t = 0;
        a0 = acc_n;
        @(negedge clk);
        cmd_src = s;
        cmd_dst = d;
        cmd_count = c;
        cmd_valid = 1'b1;
        while (acc_n == a0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        chk("accept", 64'(acc_n - a0), 64'd1);
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (done_n < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", 64'(done_n >= target), 64'd1);
    endtask

    logic [7:0]  exp_addr [0:6] = '{8'h44, 8'h48, 8'h4C, 8'h50, 8'h54, 8'h58, 8'h40};
    logic [31:0] exp_nom  [0:6] = '{32'h1, 32'h2345_6780, 32'h2, 32'h0, 32'h0, 32'h1000, 32'h1};
    logic [31:0] exp_b2b1 [0:6] = '{32'hA, 32'h0000_0001, 32'hB, 32'h0000_0002, 32'hC, 32'h0000_0003, 32'h1};
    logic [31:0] exp_b2b2 [0:6] = '{32'hD, 32'h1111_1111, 32'hE, 32'h2222_2222, 32'hF, 32'h3333_3333, 32'h1};

    int b_aw, b_w, b_ar, b_done, b_acc, t;

    initial begin
        // Reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
        chk("rst_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        chk("rst_bready", 64'(bus.M_AXI_BREADY), 64'd0);
        chk("rst_arvalid", 64'(bus.M_AXI_ARVALID), 64'd0);
        chk("rst_rready", 64'(bus.M_AXI_RREADY), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_err_resp", 64'(err_resp), 64'd0);
        chk("rst_awaddr", 64'(bus.M_AXI_AWADDR), 64'd0);
        chk("rst_araddr", 64'(bus.M_AXI_ARADDR), 64'd0);
        chk("rst_wdata", 64'(bus.M_AXI_WDATA), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("wstrb", 64'(bus.M_AXI_WSTRB), 64'hF);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'd1);

        // Nominal command
        b_aw = aw_n; b_w = w_n; b_ar = ar_n; b_done = done_n;
        busy_cycles = 60;
        send(64'h1_2345_6780, 64'h2_0000_0000, 64'h1000);
        wait_done(b_done + 1);
        repeat (10) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("nom_awaddr%0d", i), 64'(aw_log[b_aw + i]), 64'(exp_addr[i]));
            chk($sformatf("nom_wdata%0d", i), 64'(w_log[b_w + i]), 64'(exp_nom[i]));
        end
        chk("nom_aw_count", 64'(aw_n - b_aw), 64'd7);
        chk("nom_reads_ge2", 64'((ar_n - b_ar) >= 2), 64'd1);
        chk("nom_araddr_bad", 64'(ar_bad), 64'd0);
        chk("nom_done_count", 64'(done_n - b_done), 64'd1);
        chk("nom_err", 64'(last_err), 64'd0);
        chk("nom_err_resp", 64'(last_resp), 64'd0);

        // Backpressure: AW delayed, then W delayed
        for (int k = 0; k < 2; k++) begin
            aw_delay = (k == 0) ? 3 : 0;
            w_delay  = (k == 0) ? 0 : 3;
            busy_cycles = 5;
            b_aw = aw_n; b_w = w_n; b_done = done_n;
            send(64'h1_2345_6780, 64'h2_0000_0000, 64'h1000);
            wait_done(b_done + 1);
            chk($sformatf("bp%0d_aw_count", k), 64'(aw_n - b_aw), 64'd7);
            chk($sformatf("bp%0d_w_count", k), 64'(w_n - b_w), 64'd7);
            chk($sformatf("bp%0d_aw_stable", k), 64'(stab_aw), 64'd0);
            chk($sformatf("bp%0d_w_stable", k), 64'(stab_w), 64'd0);
            chk($sformatf("bp%0d_last_addr", k), 64'(aw_log[b_aw + 6]), 64'h40);
            chk($sformatf("bp%0d_wdata5", k), 64'(w_log[b_w + 5]), 64'h1000);
            chk($sformatf("bp%0d_err", k), 64'(last_err), 64'd0);
        end
        aw_delay = 0;
        w_delay = 0;

        // Write error on the third write (idx 3)
        b_aw = aw_n; b_w = w_n; b_ar = ar_n; b_done = done_n;
        berr_at = beat_n + 3;
        send(64'h1_2345_6780, 64'h2_0000_0000, 64'h1000);
        wait_done(b_done + 1);
        repeat (20) @(negedge clk);
        berr_at = 0;
        chk("werr_aw_count", 64'(aw_n - b_aw), 64'd3);
        chk("werr_w_count", 64'(w_n - b_w), 64'd3);
        chk("werr_ar_count", 64'(ar_n - b_ar), 64'd0);
        chk("werr_err", 64'(last_err), 64'd1);
        chk("werr_err_resp", 64'(last_resp), 64'd3);
        chk("werr_cmd_ready", 64'(cmd_ready), 64'd1);

        // Poll error on first read
        b_ar = ar_n; b_done = done_n;
        busy_cycles = 60;
        rerr_at = rd_n + 1;
        send(64'h1_2345_6780, 64'h2_0000_0000, 64'h1000);
        wait_done(b_done + 1);
        repeat (60) @(negedge clk);
        rerr_at = 0;
        chk("rerr_ar_count", 64'(ar_n - b_ar), 64'd1);
        chk("rerr_err", 64'(last_err), 64'd1);
        chk("rerr_err_resp", 64'(last_resp), 64'd2);
        chk("rerr_done_count", 64'(done_n - b_done), 64'd1);

        // Destination zero: START ignored, first poll reads idle
        b_aw = aw_n; b_w = w_n; b_ar = ar_n; b_done = done_n;
        send(64'h5, 64'h0, 64'h40);
        wait_done(b_done + 1);
        chk("dst0_aw_count", 64'(aw_n - b_aw), 64'd7);
        chk("dst0_dst_h", 64'(w_log[b_w + 2]), 64'd0);
        chk("dst0_dst_l", 64'(w_log[b_w + 3]), 64'd0);
        chk("dst0_ar_count", 64'(ar_n - b_ar), 64'd1);
        chk("dst0_err", 64'(last_err), 64'd0);

        // Reset during WRESP of idx 5
        b_aw = aw_n; b_done = done_n;
        busy_cycles = 60;
        send(64'h1_2345_6780, 64'h2_0000_0000, 64'h1000);
        t = 0;
        while (!((aw_n - b_aw) == 5 && bus.M_AXI_BREADY) && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("rst_mid_reached", 64'(t < 500), 64'd1);
        resetn = 1'b0;
        #1;
        chk("rst_mid_bready", 64'(bus.M_AXI_BREADY), 64'd0);
        chk("rst_mid_awvalid", 64'(bus.M_AXI_AWVALID), 64'd0);
        chk("rst_mid_wvalid", 64'(bus.M_AXI_WVALID), 64'd0);
        chk("rst_mid_cmd_ready", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rst_rel_cmd_ready", 64'(cmd_ready), 64'd1);
        repeat (40) @(negedge clk);
        chk("rst_no_done", 64'(done_n - b_done), 64'd0);
        chk("rst_no_more_aw", 64'(aw_n - b_aw), 64'd5);

        // Busy and back-to-back with cmd_valid held high
        b_aw = aw_n; b_w = w_n; b_done = done_n; b_acc = acc_n;
        busy_cycles = 5;
        @(negedge clk);
        cmd_src = 64'hA_0000_0001;
        cmd_dst = 64'hB_0000_0002;
        cmd_count = 64'hC_0000_0003;
        cmd_valid = 1'b1;
        t = 0;
        while (acc_n == b_acc && t < 100) begin
            @(negedge clk);
            t++;
        end
        cmd_src = 64'hD_1111_1111;
        cmd_dst = 64'hE_2222_2222;
        cmd_count = 64'hF_3333_3333;
        t = 0;
        while (acc_n < b_acc + 2 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        cmd_valid = 1'b0;
        chk("b2b_second_accept", 64'(acc_n - b_acc), 64'd2);
        chk("b2b_first_done_count", 64'(done_n - b_done), 64'd1);
        chk("b2b_accept_after_done", 64'(acc_cyc[b_acc + 1]), 64'(done_cyc[b_done] + 1));
        wait_done(b_done + 2);
        chk("b2b_aw_count", 64'(aw_n - b_aw), 64'd14);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("b2b1_wdata%0d", i), 64'(w_log[b_w + i]), 64'(exp_b2b1[i]));
            chk($sformatf("b2b2_wdata%0d", i), 64'(w_log[b_w + 7 + i]), 64'(exp_b2b2[i]));
            chk($sformatf("b2b2_awaddr%0d", i), 64'(aw_log[b_aw + 7 + i]), 64'(exp_addr[i]));
        end
        chk("b2b_err", 64'(last_err), 64'd0);
        chk("ar_stable", 64'(stab_ar), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
